// File: rtl/fpga_btn_debounce_if.sv
// Button conditioning bus: raw pins in, 100 Hz reference and debounced levels/events out.
interface fpga_btn_debounce_if #(
    parameter int NUM_BTN = 2
);
    logic [NUM_BTN-1:0] btn_raw;
    logic               clk_100hz;
    logic               tick_100hz;
    logic [NUM_BTN-1:0] buttons;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;

    modport master (
        output btn_raw,
        input  clk_100hz, tick_100hz, buttons, btn_press, btn_release
    );

    modport slave (
        input  btn_raw,
        output clk_100hz, tick_100hz, buttons, btn_press, btn_release
    );
endinterface

// File: rtl/fpga_btn_debounce.sv
// 100 Hz reference divider plus per-button synchroniser and tick-sampled debounce FSM.
module fpga_btn_debounce_lane #(
    parameter int DEBOUNCE_TICKS = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic sync,
    output logic level,
    output logic press,
    output logic rel
);
    localparam int CW = $clog2(DEBOUNCE_TICKS) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_TICKS - 1);

    // bit 1 of the state is the debounced level
    localparam logic [1:0] RELEASED     = 2'd0;
    localparam logic [1:0] PRESS_PEND   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_PEND = 2'd3;

    logic [1:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (tick) begin
            case (state)
                RELEASED: if (sync) begin
                    if (DEBOUNCE_TICKS == 1) begin
                        state_n = PRESSED;
                        cnt_n   = '0;
                    end else begin
                        state_n = PRESS_PEND;
                        cnt_n   = CW'(1);
                    end
                end
                PRESS_PEND: begin
                    if (!sync) begin
                        state_n = RELEASED;
                        cnt_n   = '0;
                    end else if (cnt == LAST) begin
                        state_n = PRESSED;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                PRESSED: if (!sync) begin
                    if (DEBOUNCE_TICKS == 1) begin
                        state_n = RELEASED;
                        cnt_n   = '0;
                    end else begin
                        state_n = RELEASE_PEND;
                        cnt_n   = CW'(1);
                    end
                end
                default: begin
                    if (sync) begin
                        state_n = PRESSED;
                        cnt_n   = '0;
                    end else if (cnt == LAST) begin
                        state_n = RELEASED;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    // Event pulses are registered alongside the level so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RELEASED;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            level <= state_n[1];
            press <= state_n[1] & ~state[1];
            rel   <= ~state_n[1] & state[1];
        end
    end
endmodule

module fpga_btn_debounce #(
    parameter int DIV_RATIO      = 250000,
    parameter int NUM_BTN        = 2,
    parameter int DEBOUNCE_TICKS = 3,
    parameter int CNT_W          = 18
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    fpga_btn_debounce_if.slave   bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_RATIO - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(DIV_RATIO / 2);

    logic [CNT_W-1:0]   div_cnt;
    logic               clk_reg;
    logic               tick;
    logic [NUM_BTN-1:0] sync1, sync2;
    logic [NUM_BTN-1:0] level, press, rel;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            div_cnt <= '0;
            clk_reg <= 1'b0;
            tick    <= 1'b0;
            sync1   <= '0;
            sync2   <= '0;
        end else begin
            div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + CNT_W'(1);
            tick    <= (div_cnt == LAST);
            clk_reg <= (div_cnt >= HALF);
            sync1   <= bus.btn_raw;
            sync2   <= sync1;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
        fpga_btn_debounce_lane #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_lane (
            .clk  (PCLK),
            .rst_n(PRESETn),
            .tick (tick),
            .sync (sync2[i]),
            .level(level[i]),
            .press(press[i]),
            .rel  (rel[i])
        );
    end

    assign bus.clk_100hz   = clk_reg;
    assign bus.tick_100hz  = tick;
    assign bus.buttons     = level;
    assign bus.btn_press   = press;
    assign bus.btn_release = rel;
endmodule
